// File: rtl/up3_ctrl_pkg.sv
// Shared types and constants for the up3 execution controller.
package up3_ctrl_pkg;

    typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN, S_BRK} ctrl_state_t;

    localparam logic [7:0] FETCH_ONEHOT_DEFAULT = 8'h01;

endpackage

// File: rtl/up3_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and rising-edge pulse for a
// raw button input.
module up3_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1, s2, level;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples have disagreed with level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
                pulse <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/up3_run_ctrl.sv
// Execution controller for the up3 core: single-step, divided-rate run and a
// PC breakpoint, all expressed as a one-cycle clock enable.
module up3_run_ctrl
    import up3_ctrl_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         RUN_DIV         = 25000000,
    parameter int         CNT_W           = 16,
    parameter logic [7:0] FETCH_ONEHOT    = FETCH_ONEHOT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    input  logic [7:0]       cpu_state,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic             halted,
    output logic             running,
    output logic             brk_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DIV_W = $clog2(RUN_DIV);

    ctrl_state_t      state, state_nxt;
    logic [DIV_W-1:0] div;
    logic             run_m, run_s;
    logic             step_pulse;
    logic             en_d;
    logic             is_fetch, bp_match, div_last;

    up3_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk  (clk),
        .rst  (reset),
        .din  (step_btn),
        .pulse(step_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            run_m <= run_sw;
            run_s <= run_m;
        end
    end

    // pc/cpu_state are only trusted in the cycle after a pulse
    assign is_fetch = en_d && (cpu_state == FETCH_ONEHOT);
    assign bp_match = is_fetch && bp_en && (pc == bp_addr);
    assign div_last = (div == DIV_W'(RUN_DIV - 1));
    assign cpu_en   = (state == S_STEP) || ((state == S_RUN) && div_last);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HALT: if (run_s) state_nxt = S_RUN;
                    else if (step_pulse) state_nxt = S_STEP;
            S_STEP: state_nxt = S_HALT;
            S_RUN:  if (!run_s) state_nxt = S_HALT;
                    else if (bp_match) state_nxt = S_BRK;
            S_BRK:  if (step_pulse) state_nxt = S_STEP;
                    else if (!run_s) state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_HALT;
            div     <= '0;
            en_d    <= 1'b0;
            halted  <= 1'b1;
            running <= 1'b0;
            brk_hit <= 1'b0;
        end else begin
            state   <= state_nxt;
            en_d    <= cpu_en;
            halted  <= (state_nxt == S_HALT);
            running <= (state_nxt == S_RUN);
            brk_hit <= (state_nxt == S_BRK);
            // leaving or entering run always restarts the divider from zero
            if ((state == S_RUN) && (state_nxt == S_RUN))
                div <= div_last ? '0 : div + DIV_W'(1);
            else
                div <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instr_count <= '0;
        else if (clr_cnt)
            instr_count <= '0;
        else if (is_fetch)
            instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_up3_run_ctrl.sv
// Bench for up3_run_ctrl: behavioural reference plus directed scenarios.
module tb_up3_run_ctrl;

    localparam int DB = 4;
    localparam int RD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_btn = 1'b0;
    logic       run_sw = 1'b0;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic [7:0] pc = 8'h00;
    logic [7:0] cpu_state = 8'h00;
    logic       clr_cnt = 1'b0;
    logic       cpu_en, halted, running, brk_hit;
    logic [7:0] instr_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_count = 0;
    int last_en_cyc = 0;
    bit core_auto = 1'b0;

    up3_run_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (RD),
        .CNT_W          (8),
        .FETCH_ONEHOT   (8'h01)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_state  (cpu_state),
        .clr_cnt    (clr_cnt),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .running    (running),
        .brk_hit    (brk_hit),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=halt 1=step 2=run 3=break
    int m_mode = 0;
    int m_runcyc = 0;
    int m_cnt = 0;
    bit m_en = 0, m_en_d = 0, m_pulse = 0, m_level = 0;
    bit bhist[DB+2];
    bit rhist[3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_runcyc = 0; m_cnt = 0;
            m_en = 0; m_en_d = 0; m_pulse = 0; m_level = 0;
            for (int i = 0; i < DB + 2; i++) bhist[i] = 1'b0;
            for (int i = 0; i < 3; i++) rhist[i] = 1'b0;
        end else begin
            bit run_now, fetch_seen, stable;
            for (int i = DB + 1; i > 0; i--) bhist[i] = bhist[i-1];
            bhist[0] = step_btn;
            rhist[2] = rhist[1]; rhist[1] = rhist[0]; rhist[0] = run_sw;
            run_now = rhist[2];
            fetch_seen = m_en_d && (cpu_state == 8'h01);
            if (clr_cnt) m_cnt = 0;
            else if (fetch_seen) m_cnt = (m_cnt + 1) % 256;
            case (m_mode)
                0: if (run_now) begin m_mode = 2; m_runcyc = 0; end
                   else if (m_pulse) m_mode = 1;
                1: m_mode = 0;
                2: if (!run_now) m_mode = 0;
                   else if (fetch_seen && bp_en && pc == bp_addr) m_mode = 3;
                   else m_runcyc++;
                default: if (m_pulse) m_mode = 1;
                         else if (!run_now) m_mode = 0;
            endcase
            // the button level settles once DB synchronized samples agree
            stable = 1'b1;
            for (int k = 2; k < DB + 2; k++) if (bhist[k] != bhist[2]) stable = 1'b0;
            m_pulse = 1'b0;
            if (stable && bhist[2] != m_level) begin
                m_level = bhist[2];
                m_pulse = m_level;
            end
            m_en_d = m_en;
            m_en = (m_mode == 1) || (m_mode == 2 && (m_runcyc % RD) == RD - 1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chk("cpu_en", cpu_en, m_en);
        chk("halted", halted, m_mode == 0);
        chk("running", running, m_mode == 2);
        chk("brk_hit", brk_hit, m_mode == 3);
        chk("instr_count", instr_count, m_cnt);
        if (cpu_en) begin
            en_count++;
            last_en_cyc = cyc;
        end
    end

    // Stand-in for the up3 core: each enable advances pc into a fetch
    always @(negedge clk) begin
        if (core_auto && cpu_en) begin
            pc = pc + 8'd1;
            cpu_state = 8'h01;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_en(input int target, input int budget, input string nm);
        int b = budget;
        while (en_count < target && b > 0) begin tick(1); b--; end
        if (en_count < target) chk({nm, "_timeout"}, en_count, target);
    endtask

    task automatic press(input int n);
        step_btn = 1'b1;
        tick(n);
        step_btn = 1'b0;
    endtask

    initial begin
        int e0, e1, t0, b;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_halted", halted, 1);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_count", instr_count, 0);

        // glitches then a clean press
        e0 = en_count;
        press(2); tick(3); press(2); tick(3);
        chk("glitch_no_pulse", en_count - e0, 0);
        @(negedge clk);
        step_btn = 1'b1;
        t0 = cyc;
        tick(10);
        step_btn = 1'b0;
        tick(12);
        chk("step_one_pulse", en_count - e0, 1);
        chk("step_latency", last_en_cyc - t0, 7);
        chk("step_halted", halted, 1);

        // continuous run
        pc = 8'h00; cpu_state = 8'h00; core_auto = 1'b1;
        e0 = en_count;
        run_sw = 1'b1;
        wait_en(e0 + 5, 40, "run5");
        tick(2);
        chk("run_count5", instr_count, 5);
        run_sw = 1'b0;
        tick(3);
        chk("run_stop_halted", halted, 1);
        e1 = en_count;
        tick(10);
        chk("run_stop_quiet", en_count - e1, 0);

        // breakpoint at pc 4
        pc = 8'h00; cpu_state = 8'h00;
        bp_en = 1'b1; bp_addr = 8'h04;
        e0 = en_count;
        run_sw = 1'b1;
        b = 60;
        while (!brk_hit && b > 0) begin tick(1); b--; end
        chk("bp_reached", brk_hit, 1);
        chk("bp_pulses", en_count - e0, 4);
        e1 = en_count;
        tick(10);
        chk("bp_quiet", en_count - e1, 0);
        chk("bp_hold", brk_hit, 1);

        // step out of the break, then resume via run 0->1
        e0 = en_count;
        run_sw = 1'b0;
        press(10);
        tick(10);
        chk("brk_step_pulse", en_count - e0, 1);
        chk("brk_step_halt", halted, 1);
        e1 = en_count;
        run_sw = 1'b1;
        wait_en(e1 + 3, 30, "resume");
        chk("resume_no_rebreak", brk_hit, 0);
        chk("resume_running", running, 1);

        // counter wrap and clear priority
        bp_en = 1'b0;
        b = 1200;
        while (m_cnt != 255 && b > 0) begin tick(1); b--; end
        chk("cnt_ff", instr_count, 8'hFF);
        b = 10;
        while (m_cnt != 0 && b > 0) begin tick(1); b--; end
        chk("cnt_wrap", instr_count, 0);
        b = 20;
        while (m_cnt < 3 && b > 0) begin tick(1); b--; end
        b = 10;
        while (!m_en_d && b > 0) begin tick(1); b--; end
        chk("clr_setup", instr_count >= 3, 1);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_wins", instr_count, 0);

        // asynchronous reset in the middle of a run
        tick(6);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_cpu_en", cpu_en, 0);
        chk("arst_halted", halted, 1);
        chk("arst_running", running, 0);
        chk("arst_count", instr_count, 0);
        core_auto = 1'b0;
        run_sw = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        chk("post_rst_halted", halted, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
